// File: rtl/jnwtr_sar_pkg.sv
// Shared types and parameter limits for the JNWTR SAR ADC sequencer.
package jnwtr_sar_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SAMP,
        SETTLE,
        COMP
    } sar_state_e;

    localparam int N_MIN     = 2;
    localparam int N_MAX     = 16;
    localparam int TSAMP_MIN = 1;
    localparam int TSAMP_MAX = 255;

endpackage

// File: rtl/jnwtr_sar_ctrl.sv
// SAR ADC sequencer: sample phase, comparator clocking and binary search over the
// DAC bottom-plate switches, returning the code with a one-cycle DONE strobe.
module jnwtr_sar_ctrl
    import jnwtr_sar_pkg::*;
#(
    parameter int N     = 8,
    parameter int TSAMP = 4
) (
    input  logic         CK,
    input  logic         RST,
    input  logic         START,
    input  logic         CMP,
    output logic         SAMPLE,
    output logic         CMP_CK,
    output logic [N-1:0] SW,
    output logic [N-1:0] DOUT,
    output logic         BUSY,
    output logic         DONE
);

    localparam int CW = $clog2(TSAMP + 1);
    localparam int IW = $clog2(N);

    if (N < N_MIN || N > N_MAX) begin : g_bad_n
        $error("jnwtr_sar_ctrl: N out of range");
    end
    if (TSAMP < TSAMP_MIN || TSAMP > TSAMP_MAX) begin : g_bad_tsamp
        $error("jnwtr_sar_ctrl: TSAMP out of range");
    end

    sar_state_e    state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;
    logic [N-1:0]  sw_dec;

    // Resolve the bit under test and arm the next one below it in the same edge.
    always_comb begin
        sw_dec      = SW;
        sw_dec[idx] = ~CMP;
        if (idx != '0)
            sw_dec[idx - 1'b1] = 1'b1;
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            state  <= IDLE;
            cnt    <= '0;
            idx    <= '0;
            SAMPLE <= 1'b0;
            CMP_CK <= 1'b0;
            SW     <= '0;
            DOUT   <= '0;
            BUSY   <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START) begin
                        state  <= SAMP;
                        SAMPLE <= 1'b1;
                        SW     <= '0;
                        BUSY   <= 1'b1;
                        cnt    <= CW'(TSAMP - 1);
                    end
                end
                SAMP: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        state  <= SETTLE;
                        SAMPLE <= 1'b0;
                        SW     <= {1'b1, {(N-1){1'b0}}};
                        idx    <= IW'(N - 1);
                    end
                end
                SETTLE: begin
                    state  <= COMP;
                    CMP_CK <= 1'b1;
                end
                COMP: begin
                    CMP_CK <= 1'b0;
                    SW     <= sw_dec;
                    if (idx != '0) begin
                        idx   <= idx - 1'b1;
                        state <= SETTLE;
                    end else begin
                        DOUT  <= sw_dec;
                        DONE  <= 1'b1;
                        BUSY  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jnwtr_sar_ctrl.sv
// Directed bench for jnwtr_sar_ctrl with an ideal comparator driven from SW.
module tb_jnwtr_sar_ctrl;

    localparam int N     = 8;
    localparam int TSAMP = 4;

    logic         CK = 1'b0;
    logic         RST = 1'b1;
    logic         START = 1'b0;
    logic         CMP;
    logic         SAMPLE, CMP_CK, BUSY, DONE;
    logic [N-1:0] SW, DOUT;

    logic [7:0] vin = 8'h00;
    logic       glitch_en = 1'b0;
    logic       rnd = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    jnwtr_sar_ctrl #(.N(N), .TSAMP(TSAMP)) dut (
        .CK(CK), .RST(RST), .START(START), .CMP(CMP),
        .SAMPLE(SAMPLE), .CMP_CK(CMP_CK), .SW(SW), .DOUT(DOUT),
        .BUSY(BUSY), .DONE(DONE)
    );

    always #5 CK = ~CK;

    initial forever #3 rnd = 1'($urandom);

    // Ideal comparator; random junk whenever the comparator clock is low.
    assign CMP = (glitch_en && !CMP_CK) ? rnd : (SW > vin);

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    // One full conversion from an idle FSM; START optionally re-pulsed at edges p1/p2.
    task automatic conv(input logic [7:0] v, input int p1, input int p2, input bit trace_sw);
        int samp, ck, dn, dn_at, busy_err;
        vin   = v;
        START = 1'b1;
        tick();
        START = 1'b0;
        chk("samp_e0", SAMPLE, 1);
        chk("busy_e0", BUSY, 1);
        chk("sw_clr_e0", SW, 0);
        samp = 1; ck = 0; dn = 0; dn_at = -1; busy_err = 0;
        for (int k = 1; k <= 20; k++) begin
            START = (k == p1 || k == p2);
            tick();
            START = 1'b0;
            samp += int'(SAMPLE);
            ck   += int'(CMP_CK);
            if (DONE) begin
                dn++;
                dn_at = k;
            end
            if (k < 20 && !BUSY)
                busy_err++;
            if (trace_sw && k >= 4 && (k % 2) == 0)
                chk("sw_seq", 32'(SW), 32'h80 >> ((k - 4) / 2));
        end
        chk("samp_cycles", samp, TSAMP);
        chk("cmpck_cycles", ck, N);
        chk("done_count", dn, 1);
        chk("done_edge", dn_at, 20);
        chk("busy_during", busy_err, 0);
        chk("busy_after", BUSY, 0);
        chk("dout", DOUT, v);
        tick();
        chk("done_clear", DONE, 0);
        chk("sw_hold", SW, v);
        chk("dout_hold", DOUT, v);
    endtask

    initial begin
        int dn, dn_first, dn_last;

        // Reset state
        repeat (2) tick();
        chk("rst_sample", SAMPLE, 0);
        chk("rst_cmpck", CMP_CK, 0);
        chk("rst_sw", SW, 0);
        chk("rst_dout", DOUT, 0);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        RST = 1'b0;
        tick();

        // Basic, extremes, ignored START, comparator glitches
        conv(8'hA5, 0, 0, 1'b0);
        conv(8'h00, 0, 0, 1'b1);
        conv(8'hFF, 0, 0, 1'b0);
        conv(8'h5A, 3, 10, 1'b0);
        glitch_en = 1'b1;
        conv(8'hA5, 0, 0, 1'b0);
        glitch_en = 1'b0;

        // Back-to-back with START held high
        vin = 8'h3C;
        START = 1'b1;
        dn = 0; dn_first = -1; dn_last = -1;
        for (int k = 0; k <= 41; k++) begin
            tick();
            if (DONE) begin
                dn++;
                if (dn_first < 0) dn_first = k;
                dn_last = k;
            end
            if (k == 20) begin
                chk("b2b_dout1", DOUT, 8'h3C);
                chk("b2b_samp_low_e20", SAMPLE, 0);
                vin = 8'hC3;
            end
            if (k == 21) begin
                chk("b2b_samp_rise", SAMPLE, 1);
                chk("b2b_done_fall", DONE, 0);
            end
            if (k == 40) chk("b2b_dout_hold", DOUT, 8'h3C);
            if (k == 41) chk("b2b_dout2", DOUT, 8'hC3);
        end
        START = 1'b0;
        chk("b2b_done_count", dn, 2);
        chk("b2b_done_first", dn_first, 20);
        chk("b2b_done_last", dn_last, 41);
        tick();

        // Mid-conversion asynchronous reset
        vin = 8'hA5;
        START = 1'b1;
        tick();
        START = 1'b0;
        repeat (9) tick();
        chk("pre_rst_cmpck", CMP_CK, 1);
        #2 RST = 1'b1;
        #1;
        chk("arst_sample", SAMPLE, 0);
        chk("arst_cmpck", CMP_CK, 0);
        chk("arst_sw", SW, 0);
        chk("arst_dout", DOUT, 0);
        chk("arst_busy", BUSY, 0);
        chk("arst_done", DONE, 0);
        tick();
        #2 RST = 1'b0;
        tick();
        conv(8'h69, 0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
